fb_mem_arbiter: RTL and testbench
=================================

Name: fb_mem_arbiter

Overview:
- Arbitrates a single-port synchronous frame-buffer RAM between two requesters:
  - the CPU core: read/write, 24-bit word address;
  - the VGA controller: read-only, 16-bit word address.
- Sits between CoreTop/VGA_Controller and the frame-buffer RAM instance.
- VGA has priority by default; a starvation counter guarantees core forward progress.
- Core accesses outside the frame-buffer page complete locally without touching RAM.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 16, data width.
- FB_PAGE, 8'h00, value core_addr[23:16] must match for a RAM access.
- MAX_WAIT, 7, consecutive denied core cycles before core is forced priority (1..255).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request, held until core_ack.
- core_we  in  1  1=write, 0=read; qualified by core_req.
- core_addr  in  24  core word address.
- core_wdata  in  DATA_W  core write data.
- core_ack  out  1  combinational; request accepted at this rising edge.
- core_rvalid  out  1  registered one-cycle pulse; core_rdata valid.
- core_rdata  out  DATA_W  registered read data.
- vga_req  in  1  VGA read request, held until vga_ack.
- vga_addr  in  ADDR_W  VGA word address.
- vga_ack  out  1  combinational accept.
- vga_rvalid  out  1  registered one-cycle pulse.
- vga_rdata  out  DATA_W  registered read data.
- mem_en  out  1  registered RAM enable.
- mem_we  out  1  registered RAM write enable.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en & !mem_we.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - mem_en, mem_we, core_rvalid, vga_rvalid = 0.
  - mem_addr, mem_wdata, core_rdata, vga_rdata = 0.
  - wait_cnt = 0; pipeline tags cleared.
  - core_ack and vga_ack are 0 while reset is high.
- Address decode:
  - core_in_fb = (core_addr[23:16] == FB_PAGE).
  - RAM address = core_addr[ADDR_W-1:0].
- Arbitration (combinational, evaluated each cycle, at most one RAM grant per cycle):
  - Core out-of-page (!core_in_fb): core_ack = core_req, independent of VGA; no RAM cycle is issued. Both acks may then assert in the same cycle.
  - Force condition: force_core = core_req & core_in_fb & (wait_cnt >= MAX_WAIT).
    - If force_core: core_ack = 1, vga_ack = 0.
    - Else: vga_ack = vga_req; core_ack = core_req & core_in_fb & !vga_req.
- Starvation counter wait_cnt:
  - Increments, saturating at 255, on any cycle where core_req & core_in_fb & !core_ack.
  - Clears on a core_ack edge.
  - Holds when core_req = 0.
- Issue stage (registered at the accepting edge):
  - mem_en = 1 for an in-page core access or a VGA access; else 0.
  - mem_we = core_we for a core grant; 0 for VGA.
  - mem_addr and mem_wdata loaded from the granted requester.
  - Tag registered: CORE_RD, CORE_WR, VGA_RD, LOCAL_RD or NONE.
- Return stage: tag is delayed one more cycle to align with mem_rdata.
  - CORE_RD: core_rvalid = 1, core_rdata = mem_rdata.
  - VGA_RD: vga_rvalid = 1, vga_rdata = mem_rdata.
  - LOCAL_RD (out-of-page core read): core_rvalid = 1, core_rdata = 0.
  - Out-of-page core write: dropped silently; no rvalid.
  - In-page core write: no rvalid.
- Latency:
  - Accept at edge N → rvalid high in cycle after edge N+2 (2-cycle latency).
  - Local reads follow the same latency.
- Throughput and ordering:
  - One access per cycle; back-to-back acks allowed.
  - Requester may present its next request immediately after ack.
  - Each requester's returns arrive in accept order.
- Reset mid-operation: all in-flight tags are discarded; no rvalid pulses after reset deasserts for pre-reset requests.
- rdata registers hold their value when rvalid = 0.

Test Plan:
- Reset, then idle, then core read addr 24'h000010 with RAM[0x10] = 16'hBEEF:
  - core_ack in same cycle;
  - mem_en = 1, mem_addr = 0x0010 one edge later;
  - core_rvalid = 1, core_rdata = 16'hBEEF two edges after accept.
- Core write 24'h000020 ← 16'h1234, then VGA read 0x0020 next cycle:
  - mem_we pulse with mem_wdata = 16'h1234;
  - vga_rdata = 16'h1234.
- vga_req held high continuously with core_req high, in-page:
  - core denied exactly 7 cycles (wait_cnt 0..6 → 7);
  - 8th cycle: core_ack = 1, vga_ack = 0;
  - wait_cnt returns to 0; pattern repeats.
- Core read 24'h010005 (out of page) while vga_req high:
  - core_ack and vga_ack both 1 in the same cycle;
  - single RAM cycle (VGA);
  - core_rvalid after 2 edges with core_rdata = 0.
- Interleaved back-to-back VGA reads 0x0000..0x0003 with core reads:
  - all rvalid pulses 2 cycles after their respective acks;
  - data matches RAM contents in order.
- Assert reset one cycle after a core read accept:
  - no core_rvalid ever appears;
  - all outputs 0 during reset;
  - normal operation resumes the first cycle after reset.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer RAM arbiter: VGA reads win by default, and a starvation counter
// forces a core grant after MAX_WAIT denied cycles. Out-of-page core accesses complete locally.
module fb_mem_arbiter #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter logic [7:0]  FB_PAGE  = 8'h00,
  parameter int          MAX_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [23:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_CORE_RD,
    TAG_CORE_WR,
    TAG_VGA_RD,
    TAG_LOCAL_RD
  } tagE;

  // Core and VGA use separate tag lanes because an out-of-page core read and a VGA read can be accepted together.
  tagE        coreTag1, coreTag2, vgaTag1, vgaTag2, coreIssue;
  logic [7:0] waitCnt;
  logic       coreInFb, forceCore;

  assign coreInFb  = (core_addr[23:16] == FB_PAGE);
  assign forceCore = core_req && coreInFb && (waitCnt >= 8'(MAX_WAIT));

  always_comb begin
    core_ack = 1'b0;
    vga_ack  = 1'b0;
    if (!reset) begin
      if (core_req && !coreInFb) begin
        core_ack = 1'b1;
        vga_ack  = vga_req;
      end else if (forceCore) begin
        core_ack = 1'b1;
      end else begin
        vga_ack  = vga_req;
        core_ack = core_req && coreInFb && !vga_req;
      end
    end
  end

  always_comb begin
    coreIssue = TAG_NONE;
    if (core_ack) begin
      if (!coreInFb)
        coreIssue = core_we ? TAG_NONE : TAG_LOCAL_RD;
      else
        coreIssue = core_we ? TAG_CORE_WR : TAG_CORE_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      vga_rvalid  <= 1'b0;
      vga_rdata   <= '0;
      coreTag1    <= TAG_NONE;
      coreTag2    <= TAG_NONE;
      vgaTag1     <= TAG_NONE;
      vgaTag2     <= TAG_NONE;
      waitCnt     <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (core_ack && coreInFb) begin
        mem_en    <= 1'b1;
        mem_we    <= core_we;
        mem_addr  <= core_addr[ADDR_W-1:0];
        mem_wdata <= core_wdata;
      end else if (vga_ack) begin
        mem_en   <= 1'b1;
        mem_addr <= vga_addr;
      end

      coreTag1 <= coreIssue;
      vgaTag1  <= vga_ack ? TAG_VGA_RD : TAG_NONE;
      coreTag2 <= coreTag1;
      vgaTag2  <= vgaTag1;

      // The second tag stage lines up with mem_rdata, so the return registers capture it here.
      core_rvalid <= (coreTag2 == TAG_CORE_RD) || (coreTag2 == TAG_LOCAL_RD);
      if (coreTag2 == TAG_CORE_RD)
        core_rdata <= mem_rdata;
      else if (coreTag2 == TAG_LOCAL_RD)
        core_rdata <= '0;

      vga_rvalid <= (vgaTag2 == TAG_VGA_RD);
      if (vgaTag2 == TAG_VGA_RD)
        vga_rdata <= mem_rdata;

      if (core_ack)
        waitCnt <= '0;
      else if (core_req && coreInFb && (waitCnt != 8'hFF))
        waitCnt <= waitCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a small synchronous RAM model.
// Inputs change 1 time unit after each rising edge, and acks are checked 1 time unit later.
module tb_fb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [23:0] core_addr;
  logic [15:0] core_wdata;
  logic        core_ack, core_rvalid;
  logic [15:0] core_rdata;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_ack, vga_rvalid;
  logic [15:0] vga_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] memRdata;

  logic [15:0] ram [0:255];
  int          errors = 0;
  int          checks = 0;

  logic        isVgaTab [6];
  logic [15:0] addrTab  [6];
  logic [15:0] dataTab  [6];

  fb_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  // The RAM preloads on reset: word i holds 16'hA000|i, and word 0x10 holds 16'hBEEF.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= (i == 16) ? 16'hBEEF : (16'hA000 | 16'(i));
      memRdata <= '0;
    end else if (mem_en) begin
      if (mem_we)
        ram[mem_addr[7:0]] <= mem_wdata;
      else
        memRdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    vga_req    = 1'b0;
    vga_addr   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    core_req = 1'b1;
    vga_req  = 1'b1;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_acks: got %b expected 00", {core_ack, vga_ack});
    end
    cycle();
    cycle();
    checks++;
    if ({mem_en, mem_we, core_rvalid, vga_rvalid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {mem_en, mem_we, core_rvalid, vga_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, core_rdata, vga_rdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, core_rdata, vga_rdata});
    end
    reset = 1'b0;
    idleInputs();
    cycle();
    checks++;
    if ({mem_en, core_ack, vga_ack} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle: got %b expected 000", {mem_en, core_ack, vga_ack});
    end
  endtask

  task automatic test_core_read();
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 24'h000010;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rd_ack: got %b expected 10", {core_ack, vga_ack});
    end
    cycle();
    core_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0010}) begin
      errors++;
      $display("[TB] FAIL rd_issue: got en=%b we=%b addr=%h expected en=1 we=0 addr=0010", mem_en, mem_we, mem_addr);
    end
    cycle();
    checks++;
    if ({core_rvalid, mem_en} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rd_early: got rvalid=%b en=%b expected 0 0", core_rvalid, mem_en);
    end
    cycle();
    checks++;
    if (core_rvalid !== 1'b1 || core_rdata !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL rd_return: got rvalid=%b data=%h expected 1 BEEF", core_rvalid, core_rdata);
    end
    cycle();
    checks++;
    if (core_rvalid !== 1'b0 || core_rdata !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL rd_hold: got rvalid=%b data=%h expected 0 BEEF", core_rvalid, core_rdata);
    end
  endtask

  task automatic test_write_then_vga();
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 24'h000020;
    core_wdata = 16'h1234;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wr_ack: got %b expected 10", {core_ack, vga_ack});
    end
    cycle();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0020, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL wr_issue: got en=%b we=%b addr=%h data=%h expected 1 1 0020 1234", mem_en, mem_we, mem_addr, mem_wdata);
    end
    core_req = 1'b0;
    core_we  = 1'b0;
    vga_req  = 1'b1;
    vga_addr = 16'h0020;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL vga_ack: got %b expected 01", {core_ack, vga_ack});
    end
    cycle();
    vga_req = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0020}) begin
      errors++;
      $display("[TB] FAIL vga_issue: got en=%b we=%b addr=%h expected 1 0 0020", mem_en, mem_we, mem_addr);
    end
    cycle();
    checks++;
    if (core_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_no_rvalid: got %b expected 0", core_rvalid);
    end
    cycle();
    checks++;
    if (vga_rvalid !== 1'b1 || vga_rdata !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL vga_return: got rvalid=%b data=%h expected 1 1234", vga_rvalid, vga_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] expAck;
    vga_req   = 1'b1;
    vga_addr  = 16'h0002;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 24'h000001;
    for (int i = 0; i < 16; i++) begin
      expAck = ((i % 8) == 7) ? 2'b10 : 2'b01;
      #1;
      checks++;
      if ({core_ack, vga_ack} !== expAck) begin
        errors++;
        $display("[TB] FAIL starve_cycle%0d: got %b expected %b", i, {core_ack, vga_ack}, expAck);
      end
      cycle();
    end
    idleInputs();
    cycle();
    cycle();
    cycle();
  endtask

  task automatic test_out_of_page();
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 24'h010005;
    vga_req   = 1'b1;
    vga_addr  = 16'h0003;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL oop_acks: got %b expected 11", {core_ack, vga_ack});
    end
    cycle();
    idleInputs();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0003}) begin
      errors++;
      $display("[TB] FAIL oop_issue: got en=%b we=%b addr=%h expected 1 0 0003", mem_en, mem_we, mem_addr);
    end
    cycle();
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oop_single_ram: got en=%b expected 0", mem_en);
    end
    cycle();
    checks++;
    if ({core_rvalid, vga_rvalid, core_rdata, vga_rdata} !== {2'b11, 16'h0000, 16'hA003}) begin
      errors++;
      $display("[TB] FAIL oop_return: got cv=%b vv=%b cd=%h vd=%h expected 1 1 0000 A003", core_rvalid, vga_rvalid, core_rdata, vga_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    isVgaTab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    addrTab  = '{16'h0000, 16'h0020, 16'h0001, 16'h0010, 16'h0002, 16'h0003};
    dataTab  = '{16'hA000, 16'h1234, 16'hA001, 16'hBEEF, 16'hA002, 16'hA003};
    for (int t = 0; t < 8; t++) begin
      idleInputs();
      if (t < 6) begin
        if (isVgaTab[t]) begin
          vga_req  = 1'b1;
          vga_addr = addrTab[t];
        end else begin
          core_req  = 1'b1;
          core_addr = {8'h00, addrTab[t]};
        end
        #1;
        checks++;
        if ({core_ack, vga_ack} !== {!isVgaTab[t], isVgaTab[t]}) begin
          errors++;
          $display("[TB] FAIL b2b_ack%0d: got %b expected %b", t, {core_ack, vga_ack}, {!isVgaTab[t], isVgaTab[t]});
        end
      end
      cycle();
      if (t >= 2) begin
        s = t - 2;
        checks++;
        if ({core_rvalid, vga_rvalid} !== {!isVgaTab[s], isVgaTab[s]} ||
            (isVgaTab[s] ? vga_rdata : core_rdata) !== dataTab[s]) begin
          errors++;
          $display("[TB] FAIL b2b_ret%0d: got cv=%b vv=%b cd=%h vd=%h expected data %h", s, core_rvalid, vga_rvalid, core_rdata, vga_rdata, dataTab[s]);
        end
      end
    end
    idleInputs();
    cycle();
  endtask

  task automatic test_reset_mid();
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 24'h000010;
    #1;
    checks++;
    if (core_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_accept: got %b expected 1", core_ack);
    end
    cycle();
    reset   = 1'b1;
    vga_req = 1'b1;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_reset_acks: got %b expected 00", {core_ack, vga_ack});
    end
    cycle();
    checks++;
    if ({mem_en, mem_we, core_rvalid, vga_rvalid, mem_addr, core_rdata} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outs: got en=%b rv=%b addr=%h cd=%h expected all 0", mem_en, core_rvalid, mem_addr, core_rdata);
    end
    cycle();
    checks++;
    if (core_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_no_rvalid: got %b expected 0", core_rvalid);
    end
    reset = 1'b0;
    idleInputs();
    vga_req  = 1'b1;
    vga_addr = 16'h0001;
    #1;
    checks++;
    if ({core_ack, vga_ack} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_resume_ack: got %b expected 01", {core_ack, vga_ack});
    end
    cycle();
    vga_req = 1'b0;
    checks++;
    if ({mem_en, core_rvalid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_resume_issue: got en=%b rv=%b expected 1 0", mem_en, core_rvalid);
    end
    cycle();
    checks++;
    if (core_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_stale_rvalid: got %b expected 0", core_rvalid);
    end
    cycle();
    checks++;
    if ({core_rvalid, vga_rvalid, vga_rdata} !== {2'b01, 16'hA001}) begin
      errors++;
      $display("[TB] FAIL mid_resume_ret: got cv=%b vv=%b vd=%h expected 0 1 A001", core_rvalid, vga_rvalid, vga_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_write_then_vga();
    test_starvation();
    test_out_of_page();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
